// File: rtl/decoder_b_insn_pkg.sv
// Shared constants for the RV branch decoder: the BRANCH major opcode and the
// funct3 encodings of the six conditional branches.
package decoder_b_insn_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/decoder_b_insn_cond.sv
// Branch condition evaluation: picks the single comparison flag named by funct3
// and flags the two reserved funct3 encodings.
module decoder_b_cond
    import decoder_b_insn_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       EQ,
    input  logic       LS,
    input  logic       LU,
    output logic       take,
    output logic       illegal
);

    // A case per encoding keeps an unknown value on an unselected flag out of take.
    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  take = EQ;
            F3_BNE:  take = ~EQ;
            F3_BLT:  take = LS;
            F3_BGE:  take = ~LS;
            F3_BLTU: take = LU;
            F3_BGEU: take = ~LU;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decoder_b_insn.sv
// B-type instruction decoder: zero-latency branch decision and immediate,
// plus wrapping statistics counters of legal branches decoded and taken.
module decoder_b_insn
    import decoder_b_insn_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      insn,
    input  logic             EQ,
    input  logic             LS,
    input  logic             LU,
    input  logic             insn_valid,
    output logic             pc_alu_sel,
    output logic [XLEN-1:0]  imm_b,
    output logic             is_branch,
    output logic             illegal_branch,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic cond_take;
    logic cond_illegal;
    logic count_en;
    logic unused_rs_fields;

    // rs1/rs2 fields are resolved upstream into EQ/LS/LU.
    assign unused_rs_fields = ^insn[24:15];

    decoder_b_cond u_cond (
        .funct3  (insn[14:12]),
        .EQ      (EQ),
        .LS      (LS),
        .LU      (LU),
        .take    (cond_take),
        .illegal (cond_illegal)
    );

    assign is_branch      = (insn[6:0] == OPC_BRANCH);
    assign pc_alu_sel     = is_branch & cond_take;
    assign illegal_branch = is_branch & cond_illegal;

    assign imm_b = {{(XLEN-13){insn[31]}}, insn[31], insn[7],
                    insn[30:25], insn[11:8], 1'b0};

    assign count_en = insn_valid & is_branch & ~illegal_branch;

    // An unknown insn_valid makes the if condition false, so counters hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (count_en) begin
            branch_cnt <= branch_cnt + CNT_ONE;
            if (pc_alu_sel) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_decoder_b_insn.sv
// Self-checking bench for decoder_b_insn: randomized operands and instructions
// compared against a reference model built from real rs1/rs2 comparisons.
module tb_decoder_b_insn;

    localparam int XLEN  = 64;
    localparam int CNT_W = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      insn;
    logic             EQ;
    logic             LS;
    logic             LU;
    logic             insn_valid;
    logic             pc_alu_sel;
    logic [XLEN-1:0]  imm_b;
    logic             is_branch;
    logic             illegal_branch;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int checks = 0;
    int passed = 0;
    int exp_branch = 0;
    int exp_taken  = 0;

    decoder_b_insn #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .insn           (insn),
        .EQ             (EQ),
        .LS             (LS),
        .LU             (LU),
        .insn_valid     (insn_valid),
        .pc_alu_sel     (pc_alu_sel),
        .imm_b          (imm_b),
        .is_branch      (is_branch),
        .illegal_branch (illegal_branch),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    always #5 clk = ~clk;

    // Immediate as a signed byte offset built from weighted bit fields.
    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        int off;
        off = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0)
            + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        return 64'(longint'(off));
    endfunction

    function automatic bit ref_is_branch(input logic [31:0] w);
        return w[6:0] == 7'b1100011;
    endfunction

    function automatic bit ref_reserved(input logic [2:0] f3);
        return (f3 == 3'd2) || (f3 == 3'd3);
    endfunction

    // Branch outcome from actual register values.
    function automatic bit ref_taken_regs(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Branch outcome from raw flags (flags may be mutually inconsistent).
    function automatic bit ref_taken_flags(input logic [2:0] f3, input bit eq,
                                           input bit ls, input bit lu);
        case (f3)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd4:    return ls;
            3'd5:    return !ls;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] make_branch(input logic [2:0] f3);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = 7'b1100011;
        w[14:12] = f3;
        return w;
    endfunction

    function automatic logic [63:0] rand_reg();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_regs(input logic [63:0] a, input logic [63:0] b);
        EQ = (a == b);
        LS = ($signed(a) < $signed(b));
        LU = (a < b);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        insn       = 32'h00520463;
        EQ         = 1'b1;
        LS         = 1'b0;
        LU         = 1'b0;
        insn_valid = 1'b1;
        repeat (2) @(negedge clk);
        exp_branch = 0;
        exp_taken  = 0;
        checks++;
        if (branch_cnt !== 8'd0) $display("[TB] FAIL reset_branch_cnt got %0d want 0", branch_cnt);
        else passed++;
        checks++;
        if (taken_cnt !== 8'd0) $display("[TB] FAIL reset_taken_cnt got %0d want 0", taken_cnt);
        else passed++;
        checks++;
        if (pc_alu_sel !== 1'b1) $display("[TB] FAIL reset_comb_sel got %b want 1", pc_alu_sel);
        else passed++;
        insn_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_beq_example();
        insn = 32'h00520463;
        EQ   = 1'b1;
        LS   = 1'bx;
        LU   = 1'bx;
        #1;
        checks++;
        if (pc_alu_sel !== 1'b1) $display("[TB] FAIL beq_eq1_sel got %b want 1", pc_alu_sel);
        else passed++;
        checks++;
        if (imm_b !== 64'd8) $display("[TB] FAIL beq_imm got %h want 8", imm_b);
        else passed++;
        checks++;
        if (is_branch !== 1'b1 || illegal_branch !== 1'b0)
            $display("[TB] FAIL beq_flags got br=%b ill=%b want br=1 ill=0", is_branch, illegal_branch);
        else passed++;
        checks++;
        if ($isunknown({pc_alu_sel, imm_b, is_branch, illegal_branch}))
            $display("[TB] FAIL beq_no_x got sel=%b br=%b want known", pc_alu_sel, is_branch);
        else passed++;
        EQ = 1'b0;
        #2;
        checks++;
        if (pc_alu_sel !== 1'b0) $display("[TB] FAIL beq_eq0_sel got %b want 0", pc_alu_sel);
        else passed++;
    endtask

    task automatic test_imm_and_non_branch();
        insn = 32'hFE000EE3;
        EQ = 1'b1; LS = 1'b0; LU = 1'b0;
        #1;
        checks++;
        if (imm_b !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("[TB] FAIL imm_neg4 got %h want fffffffffffffffc", imm_b);
        else passed++;
        insn = 32'h00000013;
        #1;
        checks++;
        if (pc_alu_sel !== 1'b0 || is_branch !== 1'b0 || illegal_branch !== 1'b0)
            $display("[TB] FAIL addi_flags got sel=%b br=%b ill=%b want 0 0 0",
                     pc_alu_sel, is_branch, illegal_branch);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [2:0] f3;
        bit eq, ls, lu, exp_sel, exp_ill;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                f3 = 3'(f);
                eq = c[0]; ls = c[1]; lu = c[2];
                insn = make_branch(f3);
                EQ = eq; LS = ls; LU = lu;
                #1;
                exp_sel = ref_taken_flags(f3, eq, ls, lu);
                exp_ill = ref_reserved(f3);
                checks++;
                if (pc_alu_sel !== exp_sel || illegal_branch !== exp_ill)
                    $display("[TB] FAIL sweep f3=%0d flags=%b%b%b got sel=%b ill=%b want sel=%b ill=%b",
                             f3, eq, ls, lu, pc_alu_sel, illegal_branch, exp_sel, exp_ill);
                else passed++;
            end
        end
    endtask

    task automatic test_random_comb();
        logic [31:0] w;
        logic [63:0] a, b;
        bit br, exp_sel, exp_ill;
        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 1) == 1) ? make_branch(3'($urandom)) : $urandom;
            a = rand_reg();
            b = ($urandom_range(0, 3) == 0) ? a : rand_reg();
            insn = w;
            drive_regs(a, b);
            #1;
            br = ref_is_branch(w);
            exp_sel = br && ref_taken_regs(w[14:12], a, b);
            exp_ill = br && ref_reserved(w[14:12]);
            checks++;
            if (pc_alu_sel !== exp_sel || is_branch !== br || illegal_branch !== exp_ill
                || imm_b !== ref_imm(w))
                $display("[TB] FAIL rand_comb insn=%h got sel=%b br=%b ill=%b imm=%h want sel=%b br=%b ill=%b imm=%h",
                         w, pc_alu_sel, is_branch, illegal_branch, imm_b,
                         exp_sel, br, exp_ill, ref_imm(w));
            else passed++;
        end
    endtask

    task automatic test_counters();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            insn = 32'h00520463;
            EQ = (i < 5); LS = 1'b0; LU = 1'b0;
            insn_valid = 1'b1;
            @(negedge clk);
        end
        insn_valid = 1'b0;
        checks++;
        if (branch_cnt !== 8'd8 || taken_cnt !== 8'd5)
            $display("[TB] FAIL count_8_5 got %0d/%0d want 8/5", branch_cnt, taken_cnt);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (branch_cnt !== 8'd0 || taken_cnt !== 8'd0)
            $display("[TB] FAIL midcycle_reset got %0d/%0d want 0/0", branch_cnt, taken_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        insn = 32'h00520463; EQ = 1'b1; insn_valid = 1'b1;
        @(negedge clk);
        insn_valid = 1'b0;
        checks++;
        if (branch_cnt !== 8'd1 || taken_cnt !== 8'd1)
            $display("[TB] FAIL resume_count got %0d/%0d want 1/1", branch_cnt, taken_cnt);
        else passed++;
        exp_branch = 1;
        exp_taken  = 1;
    endtask

    task automatic test_random_counting();
        logic [31:0] w;
        logic [63:0] a, b;
        bit v;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       w = $urandom;
                1:       w = make_branch(3'($urandom_range(2, 3)));
                default: w = make_branch(3'($urandom));
            endcase
            a = rand_reg();
            b = ($urandom_range(0, 2) == 0) ? a : rand_reg();
            v = ($urandom_range(0, 3) != 0);
            insn = w;
            drive_regs(a, b);
            insn_valid = v;
            if (v && ref_is_branch(w) && !ref_reserved(w[14:12])) begin
                exp_branch = (exp_branch + 1) % CNT_MOD;
                if (ref_taken_regs(w[14:12], a, b)) exp_taken = (exp_taken + 1) % CNT_MOD;
            end
            @(negedge clk);
            checks++;
            if (branch_cnt !== CNT_W'(exp_branch) || taken_cnt !== CNT_W'(exp_taken))
                $display("[TB] FAIL rand_count cyc=%0d got %0d/%0d want %0d/%0d",
                         i, branch_cnt, taken_cnt, exp_branch, exp_taken);
            else passed++;
        end
        insn_valid = 1'b0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        insn = 32'h00520463; EQ = 1'b1; LS = 1'b0; LU = 1'b0;
        insn_valid = 1'b1;
        repeat (CNT_MOD - 1) @(negedge clk);
        insn_valid = 1'b0;
        checks++;
        if (branch_cnt !== 8'hFF || taken_cnt !== 8'hFF)
            $display("[TB] FAIL preload_max got %0d/%0d want 255/255", branch_cnt, taken_cnt);
        else passed++;
        insn_valid = 1'b1;
        @(negedge clk);
        insn_valid = 1'b0;
        checks++;
        if (branch_cnt !== 8'd0 || taken_cnt !== 8'd0)
            $display("[TB] FAIL wrap_zero got %0d/%0d want 0/0", branch_cnt, taken_cnt);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (branch_cnt !== 8'd0 || taken_cnt !== 8'd0)
                $display("[TB] FAIL idle_hold cyc=%0d got %0d/%0d want 0/0",
                         i, branch_cnt, taken_cnt);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_beq_example();
        test_imm_and_non_branch();
        test_sweep();
        test_random_comb();
        test_counters();
        test_random_counting();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
